// File: rtl/fir4_dec_fifo.sv
// fir4_dec_fifo: rounded 4-sample average of the FIR sum, decimated into a FIFO.
// Optional saturating drop counter port when FIR4_DEC_DROPCNT_EN is defined.
module fir4_dec_fifo #(
  parameter int w      = 16,
  parameter int DW     = 4,
  parameter int DEPTH  = 4,
  parameter int WARMUP = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [w+1:0]  s_in,
  input  logic [DW-1:0] dec,
  output logic [w-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overrun
`ifdef FIR4_DEC_DROPCNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WUW = $clog2(WARMUP + 2);

  logic [WUW-1:0] wu_q, wu_d;
  logic [DW-1:0]  ph_q, ph_d;
  logic [DW-1:0]  d_q, d_d;
  logic [DW-1:0]  dec_n, d_cur;
  logic [w-1:0]   mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovr_q;

  logic           warm, sel, full;
  logic           pop, push, drop;
  logic [w+2:0]   sum;
  logic [w-1:0]   avg;
  logic           unused_ok;

  assign warm  = (wu_q == WUW'(WARMUP));
  assign dec_n = (dec == '0) ? DW'(1) : dec;
  // dec is only honoured at the start of a period
  assign d_cur = (ph_q == '0) ? dec_n : d_q;
  assign sel   = warm && (ph_q == '0);

  assign sum       = {1'b0, s_in} + (w+3)'(2);
  assign avg       = sum[w+1:2];
  assign unused_ok = ^{sum[w+2], sum[1:0]};

  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rd_q];
  assign overrun   = ovr_q;

  assign full = (cnt_q == CW'(DEPTH));
  assign pop  = out_valid && out_ready;
  assign push = sel && (!full || pop);
  assign drop = sel && full && !pop;

  always_comb begin
    wu_d = wu_q;
    if (!warm) wu_d = wu_q + WUW'(1);
  end

  always_comb begin
    ph_d = ph_q;
    d_d  = d_q;
    if (warm) begin
      if (ph_q == '0) d_d = dec_n;
      if (ph_q == d_cur - DW'(1)) ph_d = '0;
      else ph_d = ph_q + DW'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wu_q  <= '0;
      ph_q  <= '0;
      d_q   <= DW'(1);
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wu_q  <= wu_d;
      ph_q  <= ph_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wr_q] <= avg;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      if (drop) ovr_q <= 1'b1;
    end
  end

`ifdef FIR4_DEC_DROPCNT_EN
  logic [7:0] dc_q;

  assign drop_cnt = dc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dc_q <= '0;
    end else if (drop && (dc_q != 8'hFF)) begin
      dc_q <= dc_q + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir4_dec_fifo.sv
// tb_fir4_dec_fifo: vector table, directed corner sequences and random run
// against a queue-based reference of the averaging decimator FIFO.
module tb_fir4_dec_fifo;

  localparam int W      = 16;
  localparam int DW     = 4;
  localparam int DEPTH  = 4;
  localparam int WARMUP = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W+1:0]  s_in = '0;
  logic [DW-1:0] dec = 4'd1;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          overrun;
`ifdef FIR4_DEC_DROPCNT_EN
  logic [7:0]    drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mq [$];
  bit           m_ovr;
  int           m_drops;
  int           m_since;
  int           m_next;

  typedef struct {
    logic [W+1:0] s;
    logic [W-1:0] e;
  } rvec_t;

  rvec_t rv [10];

  always #5 clk = ~clk;

  fir4_dec_fifo #(
    .w(W), .DW(DW), .DEPTH(DEPTH), .WARMUP(WARMUP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_in(s_in),
    .dec(dec),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun(overrun)
`ifdef FIR4_DEC_DROPCNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_avg(logic [W+1:0] s);
    int t;
    t = (int'(s) + 2) / 4;
    return t[W-1:0];
  endfunction

  // Reference: cycles since reset release, next selection time, output queue.
  task automatic model_edge();
    bit pop;
    bit sel;
    int d;
    if (reset) begin
      mq.delete();
      m_ovr   = 1'b0;
      m_drops = 0;
      m_since = 0;
      m_next  = WARMUP;
      return;
    end
    pop = (mq.size() != 0) && out_ready;
    sel = (m_since == m_next);
    if (sel) begin
      d      = (dec == 0) ? 1 : int'(dec);
      m_next = m_since + d;
    end
    if (pop) void'(mq.pop_front());
    if (sel) begin
      if (mq.size() < DEPTH) mq.push_back(ref_avg(s_in));
      else begin
        m_ovr = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    m_since++;
  endtask

  task automatic compare_all();
    chk("valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) chk("data", out_data, mq[0]);
    chk("overrun", overrun, m_ovr);
`ifdef FIR4_DEC_DROPCNT_EN
    chk("drop_cnt", drop_cnt, m_drops);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] got [$];
    int dexp [10];

    rv[0] = '{18'd6,      16'd2};
    rv[1] = '{18'd5,      16'd1};
    rv[2] = '{18'd7,      16'd2};
    rv[3] = '{18'd262140, 16'd65535};
    rv[4] = '{18'd100,    16'd25};
    rv[5] = '{18'd0,      16'd0};
    rv[6] = '{18'd1,      16'd0};
    rv[7] = '{18'd2,      16'd1};
    rv[8] = '{18'd3,      16'd1};
    rv[9] = '{18'd262137, 16'd65534};
    dexp  = '{5, 8, 11, 14, 16, 18, 20, 21, 22, 23};

    // warm-up
    dec = 4'd1;
    s_in = 18'd100;
    out_ready = 1'b1;
    do_reset(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data", out_data, 0);
    for (int i = 0; i < WARMUP; i++) begin
      step();
      chk("warm_valid0", out_valid, 0);
    end
    step();
    chk("warm_first_valid", out_valid, 1);
    chk("warm_first_data", out_data, 25);
    repeat (3) begin
      step();
      chk("warm_steady", out_valid, 1);
    end

    // rounding vectors, one in flight per cycle
    for (int i = 0; i < 10; i++) begin
      s_in = rv[i].s;
      step();
      chk("round", out_data, rv[i].e);
    end

    // decimation 3, switch to 2 mid-period, then 0
    do_reset(1);
    got.delete();
    for (int k = 0; k < 24; k++) begin
      s_in = 18'(4 * k);
      dec  = (k < 12) ? 4'd3 : (k < 19) ? 4'd2 : 4'd0;
      step();
      if (out_valid) got.push_back(out_data);
    end
    chk("dec_count", got.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < got.size()) chk("dec_seq", got[i], dexp[i]);

    // backpressure and overrun
    do_reset(1);
    dec = 4'd1;
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      s_in = 18'(4 * (k + 10));
      step();
      if (k >= WARMUP) chk("bp_frozen", out_data, 15);
    end
    chk("bp_overrun", overrun, 1);
`ifdef FIR4_DEC_DROPCNT_EN
    chk("bp_drop_cnt", drop_cnt, 1);
`endif
    out_ready = 1'b1;
    for (int k = 10; k < 13; k++) begin
      s_in = 18'(4 * (k + 10));
      step();
      chk("bp_drain", out_data, k + 6);
    end

    // full FIFO with simultaneous pop, several pointer laps
    do_reset(1);
    dec = 4'd1;
    out_ready = 1'b0;
    for (int k = 0; k < 25; k++) begin
      s_in = 18'(4 * k);
      out_ready = (k >= 9);
      step();
      if (k >= 8) begin
        chk("fp_order", out_data, k - 3);
        chk("fp_overrun", overrun, 0);
      end
    end

    // reset mid-operation
    do_reset(1);
    dec = 4'd2;
    for (int k = 0; k < 15; k++) begin
      s_in = 18'(4 * k);
      out_ready = (k == 14);
      step();
    end
    chk("mid_head", out_data, 7);
    chk("mid_overrun", overrun, 1);
    out_ready = 1'b0;
    do_reset(1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_overrun", overrun, 0);
`ifdef FIR4_DEC_DROPCNT_EN
    chk("mid_rst_drop_cnt", drop_cnt, 0);
`endif
    dec = 4'd1;
    out_ready = 1'b1;
    for (int i = 0; i < WARMUP; i++) begin
      step();
      chk("mid_warm_valid0", out_valid, 0);
    end
    step();
    chk("mid_warm_valid1", out_valid, 1);

    // random traffic
    do_reset(1);
    for (int n = 0; n < 3000; n++) begin
      s_in      = 18'($urandom_range(0, 262140));
      dec       = 4'($urandom_range(0, 4));
      out_ready = ($urandom_range(0, 1) == 1);
      reset     = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir4_dec_fifo.md
Name: fir4_dec_fifo

Overview:
- Downstream consumer of the 4-tap moving-sum FIR stage.
- Takes the FIR's registered sum (w+2 bits, one new value every clock, no stall capability) and converts it to a rounded 4-sample average (w bits).
- Decimates by a run-time factor and buffers results in a small FIFO behind a valid/ready output handshake.
- Samples produced while the FIFO is full are dropped and flagged as overrun.

Parameters:
- w, 16, input sample width of the FIR; s_in is w+2 bits, out_data is w bits.
- DW, 4, width of the decimation-factor input.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- WARMUP, 5, clocks after reset deassertion during which s_in is discarded (FIR window not yet filled).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- s_in  in  w+2  FIR moving sum; new value every clock.
- dec  in  DW  decimation factor; 0 treated as 1.
- out_data  out  w  FIFO head: rounded average.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head this cycle when high with out_valid.
- overrun  out  1  sticky; set when a selected sample is dropped.

Behaviour:
- One clock domain. Reset is synchronous and active-high; all state updates on posedge clk.
- Reset values:
  - out_valid=0, out_data=0, overrun=0.
  - FIFO pointers and count=0.
  - Warm-up counter=0, decimation phase=0, latched factor=1.
- Reset mid-operation: FIFO contents are discarded and every value above is restored on the next edge. No partial state survives.
- Warm-up:
  - A counter runs 0..WARMUP after reset deassertion, then saturates.
  - s_in is ignored while the count is below WARMUP.
  - The first candidate sample is s_in in the cycle where the count equals WARMUP.
- Decimation:
  - The phase counter runs 0..D-1, where D is the latched factor.
  - A sample is selected when phase==0 and warm-up is complete.
  - dec is sampled into D only when phase wraps to 0, or on the first post-warm-up cycle. Changes in dec mid-period take effect at the next wrap.
  - dec=0 and dec=1 both select every cycle.
- Arithmetic:
  - avg = (s_in + 2) >> 2, computed at w+3 bits: round half up, then truncate to w bits.
  - Max s_in = 4*(2^w-1) gives avg = 2^w-1, so saturation is never needed.
- FIFO:
  - Circular buffer of DEPTH x w bits; read and write pointers wrap modulo DEPTH.
  - Separate count, 0..DEPTH.
  - pop = out_valid && out_ready.
  - push = selected && (count<DEPTH || pop). A full FIFO with a simultaneous pop accepts the push, and the count is unchanged.
  - Simultaneous push and pop on an empty FIFO is not possible, since out_valid=0.
  - A push into an empty FIFO makes out_valid=1 on the next edge, with out_data equal to that average. Latency from selected s_in to out_data is 1 clock.
  - out_data always shows the entry at the read pointer. It holds stable while out_valid && !out_ready.
- Overrun:
  - When selected && count==DEPTH && !pop, the sample is dropped and overrun is set.
  - overrun clears only on reset.
- Handshake:
  - out_valid never deasserts without a pop.
  - out_data does not change while out_valid && !out_ready.

Optional Feature:
- Macro: FIR4_DEC_DROPCNT_EN.
- When defined:
  - Extra output port drop_cnt (8 bits): saturating count of dropped samples, stops at 255.
  - Reset value 0.
  - Increments in exactly the cycles where overrun would be set.
- When undefined: no drop_cnt port and no counter logic; overrun is the only drop indication.

Test Plan:
- Warm-up: reset high for 2 clocks, then low, dec=1, s_in=100 constant, out_ready=1. Required: out_valid=0 for the first WARMUP=5 clocks after deassertion, then out_valid=1 with out_data=25 one clock later, and every clock after.
- Rounding: s_in=6 -> 2; s_in=5 -> 1; s_in=7 -> 2; s_in=4*(65535)=262140 -> 65535 (w=16).
- Decimation change: dec=3 with s_in ramping +4 per clock. Required: every third value is output. dec switched to 2 mid-period changes spacing only after the next phase wrap. dec=0 behaves as dec=1.
- Backpressure: dec=1, out_ready=0 after warm-up. Required: out_valid=1 with out_data frozen, count reaches 4. The 5th selected sample is dropped and overrun=1 (drop_cnt=1 when FIR4_DEC_DROPCNT_EN). Raising out_ready then drains the 4 stored values in order.
- Full with simultaneous pop: FIFO full, out_ready=1 and a selected sample in the same cycle. Required: the push is accepted, count stays 4, overrun stays 0. Pointers wrap correctly over ≥3 full laps, verified by order checking against a reference queue.
- Reset mid-operation: with FIFO holding 3 entries and overrun=1, assert reset for 1 clock. Required: next edge gives out_valid=0, overrun=0, drop_cnt=0, and the warm-up restarts at 5 clocks.
